// File: rtl/encoder42_event_capture.sv
// encoder42_event_capture: latches rising edges on four request lines as
// pending events and presents them one at a time as a 2-bit priority index
// with a valid/ready handshake. e is an active-low capture enable.
module encoder42_event_capture #(
    parameter int unsigned PRIO_HIGH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [3:0] w,
    input  logic       rdy,
    output logic [1:0] y,
    output logic       v,
    output logic [3:0] pend,
    output logic       ovf
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [N_REQ-1:0] r_w_q;
    logic [N_REQ-1:0] r_pend;
    logic [IDX_W-1:0] r_y;
    logic             r_v;
    logic             r_ovf;

    logic [N_REQ-1:0] w_rise;
    logic             w_ack;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_pend_nxt;
    logic             w_ovf_set;
    logic [IDX_W-1:0] w_prio_idx;
    logic [IDX_W-1:0] w_y_nxt;
    logic             w_v_nxt;

    // Edge detect, acknowledge decode, and pending-set update (set wins over clear)
    always_comb begin
        w_rise     = w & ~r_w_q;
        w_ack      = (r_state == ST_PRESENT) && rdy;
        w_clr      = w_ack ? N_REQ'(4'b0001 << r_y) : '0;
        w_pend_nxt = (r_pend & ~w_clr) | (e ? '0 : w_rise);
        w_ovf_set  = !e && (|(w_rise & r_pend & ~w_clr));
    end

    // Priority index of the registered pending set
    always_comb begin
        w_prio_idx = '0;
        if (PRIO_HIGH != 0) begin
            if (r_pend[3])      w_prio_idx = 2'd3;
            else if (r_pend[2]) w_prio_idx = 2'd2;
            else if (r_pend[1]) w_prio_idx = 2'd1;
            else                w_prio_idx = 2'd0;
        end else begin
            if (r_pend[0])      w_prio_idx = 2'd0;
            else if (r_pend[1]) w_prio_idx = 2'd1;
            else if (r_pend[2]) w_prio_idx = 2'd2;
            else                w_prio_idx = 2'd3;
        end
    end

    // Next-state and presented-event logic
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_v_nxt     = r_v;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ST_PRESENT;
                    w_y_nxt     = w_prio_idx;
                    w_v_nxt     = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (rdy) begin
                    w_state_nxt = ST_IDLE;
                    w_v_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_v_nxt     = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_w_q   <= '0;
            r_pend  <= '0;
            r_y     <= '0;
            r_v     <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w_q   <= w;
            r_pend  <= w_pend_nxt;
            r_y     <= w_y_nxt;
            r_v     <= w_v_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
        end
    end

    assign y    = r_y;
    assign v    = r_v;
    assign pend = r_pend;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_encoder42_event_capture.sv
// Directed testbench for encoder42_event_capture (PRIO_HIGH = 1).
module tb_encoder42_event_capture;

    logic       clk;
    logic       rst;
    logic       e;
    logic [3:0] w;
    logic       rdy;
    logic [1:0] y;
    logic       v;
    logic [3:0] pend;
    logic       ovf;

    int errors;
    int checks;

    encoder42_event_capture #(.PRIO_HIGH(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .w    (w),
        .rdy  (rdy),
        .y    (y),
        .v    (v),
        .pend (pend),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        e = 1'b0; w = 4'b0000; rdy = 1'b0;
        do_reset();
        checks++; if (y !== 2'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_v got=%0d exp=0", v); end
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pend got=%b exp=0000", pend); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0d exp=0", ovf); end
    endtask

    task automatic test_single();
        e = 1'b0; w = 4'b0100;
        step();
        checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL single_pend got=%b exp=0100", pend); end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL single_v_early got=%0d exp=0", v); end
        step();
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL single_v got=%0d exp=1", v); end
        checks++; if (y !== 2'd2) begin errors++; $display("FAIL single_y got=%0d exp=2", y); end
        w = 4'b0000; rdy = 1'b1;
        step();
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL single_ack_v got=%0d exp=0", v); end
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL single_ack_pend got=%b exp=0000", pend); end
        rdy = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        w = 4'b1010; rdy = 1'b1;
        step();
        checks++; if (pend !== 4'b1010) begin errors++; $display("FAIL simul_pend got=%b exp=1010", pend); end
        step();
        checks++; if (v !== 1'b1 || y !== 2'd3) begin errors++; $display("FAIL simul_first got v=%0d y=%0d exp v=1 y=3", v, y); end
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0010) begin errors++; $display("FAIL simul_ack1 got v=%0d pend=%b exp v=0 pend=0010", v, pend); end
        step();
        checks++; if (v !== 1'b1 || y !== 2'd1) begin errors++; $display("FAIL simul_second got v=%0d y=%0d exp v=1 y=1", v, y); end
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL simul_done got v=%0d pend=%b exp v=0 pend=0000", v, pend); end
        w = 4'b0000; rdy = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        rdy = 1'b0; w = 4'b0001;
        step();
        step();
        checks++; if (v !== 1'b1 || y !== 2'd0) begin errors++; $display("FAIL bp_present got v=%0d y=%0d exp v=1 y=0", v, y); end
        w = 4'b0101;
        step();
        checks++; if (pend !== 4'b0101) begin errors++; $display("FAIL bp_pend got=%b exp=0101", pend); end
        step();
        checks++; if (v !== 1'b1 || y !== 2'd0) begin errors++; $display("FAIL bp_hold got v=%0d y=%0d exp v=1 y=0", v, y); end
        rdy = 1'b1;
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0100) begin errors++; $display("FAIL bp_ack got v=%0d pend=%b exp v=0 pend=0100", v, pend); end
        step();
        checks++; if (v !== 1'b1 || y !== 2'd2) begin errors++; $display("FAIL bp_next got v=%0d y=%0d exp v=1 y=2", v, y); end
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL bp_done got v=%0d pend=%b exp v=0 pend=0000", v, pend); end
        rdy = 1'b0; w = 4'b0000;
        step();
    endtask

    task automatic test_disable();
        e = 1'b1; w = 4'b1111;
        step();
        w = 4'b0000;
        step();
        checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL dis_pend got=%b exp=0000", pend); end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL dis_v got=%0d exp=0", v); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dis_ovf got=%0d exp=0", ovf); end
        e = 1'b0; w = 4'b0010;
        step();
        checks++; if (pend !== 4'b0010) begin errors++; $display("FAIL dis_reen_pend got=%b exp=0010", pend); end
        step();
        checks++; if (v !== 1'b1 || y !== 2'd1) begin errors++; $display("FAIL dis_reen_y got v=%0d y=%0d exp v=1 y=1", v, y); end
        rdy = 1'b1; w = 4'b0000;
        step();
        rdy = 1'b0;
        step();
    endtask

    task automatic test_set_over_clear();
        w = 4'b1000;
        step();
        w = 4'b0000;
        step();
        checks++; if (v !== 1'b1 || y !== 2'd3) begin errors++; $display("FAIL soc_present got v=%0d y=%0d exp v=1 y=3", v, y); end
        w = 4'b1000; rdy = 1'b1;
        step();
        checks++; if (pend !== 4'b1000 || v !== 1'b0) begin errors++; $display("FAIL soc_pend got pend=%b v=%0d exp pend=1000 v=0", pend, v); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL soc_ovf got=%0d exp=0", ovf); end
        rdy = 1'b0; w = 4'b0000;
        step();
        checks++; if (v !== 1'b1 || y !== 2'd3) begin errors++; $display("FAIL soc_represent got v=%0d y=%0d exp v=1 y=3", v, y); end
        rdy = 1'b1;
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL soc_done got v=%0d pend=%b exp v=0 pend=0000", v, pend); end
        rdy = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        w = 4'b0001;
        step();
        w = 4'b0000;
        step();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before got=%0d exp=0", ovf); end
        w = 4'b0001;
        step();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0d exp=1", ovf); end
        checks++; if (pend !== 4'b0001) begin errors++; $display("FAIL ovf_pend got=%b exp=0001", pend); end
        w = 4'b0000; rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        step();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0d exp=1", ovf); end
        checks++; if (pend !== 4'b0000 || v !== 1'b0) begin errors++; $display("FAIL ovf_drain got pend=%b v=%0d exp pend=0000 v=0", pend, v); end
    endtask

    task automatic test_reset_mid();
        w = 4'b1100; rdy = 1'b0;
        step();
        step();
        checks++; if (v !== 1'b1 || y !== 2'd3 || pend !== 4'b1100) begin errors++; $display("FAIL rmid_setup got v=%0d y=%0d pend=%b exp v=1 y=3 pend=1100", v, y, pend); end
        w = 4'b1000;
        do_reset();
        checks++; if (y !== 2'd0 || v !== 1'b0 || pend !== 4'b0000 || ovf !== 1'b0) begin errors++; $display("FAIL rmid_clear got y=%0d v=%0d pend=%b ovf=%0d exp all 0", y, v, pend, ovf); end
        step();
        checks++; if (pend !== 4'b1000) begin errors++; $display("FAIL rmid_held_pend got=%b exp=1000", pend); end
        step();
        checks++; if (v !== 1'b1 || y !== 2'd3) begin errors++; $display("FAIL rmid_event got v=%0d y=%0d exp v=1 y=3", v, y); end
        rdy = 1'b1;
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL rmid_ack got v=%0d pend=%b exp v=0 pend=0000", v, pend); end
        step();
        step();
        checks++; if (v !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL rmid_no_retrigger got v=%0d pend=%b exp v=0 pend=0000", v, pend); end
        rdy = 1'b0; w = 4'b0000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0; e = 1'b0; w = 4'b0000; rdy = 1'b0;
        #2;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_disable();
        do_reset();
        test_set_over_clear();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
